// File: rtl/mfp_7sd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mfp_7sd_pkg
// Brief   : Shared types and constants for the 8-digit 7-segment scanner.
// Revision: 1.0
// ============================================================================
package mfp_7sd_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [1:0] SEL_LO = 2'd0;
    localparam logic [1:0] SEL_HI = 2'd1;
    localparam logic [1:0] SEL_DP = 2'd2;
    localparam logic [1:0] SEL_EN = 2'd3;

    localparam logic [4:0] BLANK_CODE = 5'd31;

endpackage
`default_nettype wire

// File: rtl/mfp_7sd_regbank.sv
`default_nettype none
// ============================================================================
// Module  : mfp_7sd_regbank
// Brief   : Shadow/active display registers with frame-synchronous commit.
// Revision: 1.0
// ============================================================================
module mfp_7sd_regbank
    import mfp_7sd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [1:0]       wr_sel,
    input  logic [31:0]      wr_data,
    input  logic             commit_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [4:0]       rd_code_o,
    output logic             rd_dp_o,
    output logic             rd_en_o
);

    logic [NUM_DIGITS-1:0][4:0] sh_code_q, act_code_q, act_code_d;
    logic [NUM_DIGITS-1:0]      sh_dp_q, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]      sh_en_q, act_en_q, act_en_d;

    logic unused_wr_hi;
    assign unused_wr_hi = ^wr_data[31:20];

    // Read side sees the post-commit contents so the registered outputs of
    // the first cycle of a new frame already reflect the committed values.
    always_comb begin
        act_code_d = commit_i ? sh_code_q : act_code_q;
        act_dp_d   = commit_i ? sh_dp_q   : act_dp_q;
        act_en_d   = commit_i ? sh_en_q   : act_en_q;
    end

    assign rd_code_o = act_code_d[rd_idx_i];
    assign rd_dp_o   = act_dp_d[rd_idx_i];
    assign rd_en_o   = act_en_d[rd_idx_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_code_q  <= {NUM_DIGITS{BLANK_CODE}};
            act_code_q <= {NUM_DIGITS{BLANK_CODE}};
            sh_dp_q    <= '0;
            act_dp_q   <= '0;
            sh_en_q    <= '1;
            act_en_q   <= '1;
        end else begin
            act_code_q <= act_code_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            if (wr_en) begin
                case (wr_sel)
                    SEL_LO:  sh_code_q[3:0] <= wr_data[19:0];
                    SEL_HI:  sh_code_q[7:4] <= wr_data[19:0];
                    SEL_DP:  sh_dp_q        <= wr_data[7:0];
                    default: sh_en_q        <= wr_data[7:0];
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mfp_ahb_7sd_scanner.sv
`default_nettype none
// ============================================================================
// Module  : mfp_ahb_7sd_scanner
// Brief   : 8-digit multiplexed 7-segment scanner with anti-ghost blanking.
// Revision: 1.0
// ============================================================================
module mfp_ahb_7sd_scanner
    import mfp_7sd_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wr_data,
    output logic [7:0]  anode,
    output logic [5:0]  digit_data,
    output logic        frame_sync
);

    localparam int MAX_CNT = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               commit;

    logic [7:0]         anode_q, anode_d;
    logic [5:0]         digit_data_q, digit_data_d;
    logic               frame_sync_q;

    logic [4:0]         rd_code;
    logic               rd_dp;
    logic               rd_en;

    mfp_7sd_regbank u_regbank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .commit_i  (commit),
        .rd_idx_i  (idx_d),
        .rd_code_o (rd_code),
        .rd_dp_o   (rd_dp),
        .rd_en_o   (rd_en)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        commit  = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    commit  = (idx_q == IDX_LAST);
                end
            end
        endcase
    end

    // Outputs are derived from next-state values so they are registered yet
    // aligned with the state they describe; every digit change passes
    // through BLANK, so two anodes can never be low back to back.
    always_comb begin
        anode_d = 8'hFF;
        if (state_d == ST_SHOW && rd_en) begin
            anode_d[idx_d] = 1'b0;
        end
        digit_data_d = {~rd_dp, rd_code};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            anode_q      <= 8'hFF;
            digit_data_q <= 6'h3F;
            frame_sync_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            digit_data_q <= digit_data_d;
            frame_sync_q <= commit;
        end
    end

    assign anode      = anode_q;
    assign digit_data = digit_data_q;
    assign frame_sync = frame_sync_q;

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_7sd_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_mfp_ahb_7sd_scanner
// Brief   : Scoreboard bench for the scanner against a frame-position model.
// Revision: 1.0
// ============================================================================
module tb_mfp_ahb_7sd_scanner;

    localparam int P     = 4;
    localparam int B     = 2;
    localparam int DPER  = P + B;
    localparam int FRAME = 8 * DPER;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_sel = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic [7:0]  anode;
    logic [5:0]  digit_data;
    logic        frame_sync;

    always #5 clk = ~clk;

    mfp_ahb_7sd_scanner #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .anode      (anode),
        .digit_data (digit_data),
        .frame_sync (frame_sync)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [5:0] dd;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: cycles since reset exit plus shadow/active contents.
    logic [4:0] sh_code[8];
    logic [4:0] act_code[8];
    logic [7:0] sh_dp, act_dp, sh_en, act_en;
    int         t = 0;
    bit         mvalid = 1'b0;

    function automatic exp_t model_out();
        exp_t e;
        int p, d, ph;
        p  = t % FRAME;
        d  = p / DPER;
        ph = p % DPER;
        e.an = 8'hFF;
        if (ph >= B && act_en[d]) e.an[d] = 1'b0;
        e.dd = {~act_dp[d], act_code[d]};
        e.fs = (t > 0 && p == 0);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            sh_code[i]  = 5'd31;
            act_code[i] = 5'd31;
        end
        sh_dp = 8'h00; act_dp = 8'h00;
        sh_en = 8'hFF; act_en = 8'hFF;
        t = 0;
    endtask

    task automatic model_write(input logic [1:0] sel, input logic [31:0] data);
        case (sel)
            2'd0: for (int i = 0; i < 4; i++) sh_code[i]     = data[5*i +: 5];
            2'd1: for (int i = 0; i < 4; i++) sh_code[i + 4] = data[5*i +: 5];
            2'd2: sh_dp = data[7:0];
            default: sh_en = data[7:0];
        endcase
    endtask

    task automatic cycle(input bit rst, input bit we,
                         input logic [1:0] sel, input logic [31:0] data);
        @(posedge clk);
        #1;
        if (mvalid) sb_q.push_back(model_out());
        reset   = rst;
        wr_en   = we;
        wr_sel  = sel;
        wr_data = data;
        if (rst) begin
            model_reset();
            mvalid = 1'b1;
        end else if (mvalid) begin
            if ((t + 1) % FRAME == 0) begin
                for (int i = 0; i < 8; i++) act_code[i] = sh_code[i];
                act_dp = sh_dp;
                act_en = sh_en;
            end
            if (we) model_write(sel, data);
            t++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    logic [7:0] prev_an;
    bit         have_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("anode", {24'd0, anode}, {24'd0, e.an});
            chk("digit_data", {26'd0, digit_data}, {26'd0, e.dd});
            chk("frame_sync", {31'd0, frame_sync}, {31'd0, e.fs});
            chk("anode_onehot", {31'd0, ($countones(~anode) <= 1)}, 32'd1);
            if (have_prev && (~prev_an != 8'h00) && (~anode != 8'h00))
                chk("anode_no_direct_switch", {24'd0, anode}, {24'd0, prev_an});
            prev_an   = anode;
            have_prev = 1'b1;
        end
    end

    initial begin
        int guard;
        repeat (3) cycle(1'b1, 1'b0, 2'd0, 32'd0);
        idle(60);

        idle(20);
        cycle(1'b0, 1'b1, 2'd0, 32'h0001_8820);
        idle(100);

        cycle(1'b0, 1'b1, 2'd2, 32'h0000_0001);
        cycle(1'b0, 1'b1, 2'd3, 32'h0000_00F0);
        idle(100);

        guard = 0;
        while (!(t > 0 && t % FRAME == 0) && guard < 2 * FRAME) begin
            idle(1);
            guard++;
        end
        cycle(1'b0, 1'b1, 2'd1, 32'h000A_5A5A);
        idle(2 * FRAME + 10);

        cycle(1'b0, 1'b1, 2'd3, 32'h0000_00FF);
        guard = 0;
        while (!((t % FRAME) / DPER == 5 && (t % FRAME) % DPER >= B) && guard < 2 * FRAME) begin
            idle(1);
            guard++;
        end
        cycle(1'b1, 1'b1, 2'd0, 32'h0000_0000);
        idle(60);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0)
                cycle(1'b1, 1'b0, 2'd0, 32'd0);
            else if ($urandom_range(0, 7) == 0)
                cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom);
            else
                idle(1);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mfp_ahb_7sd_scanner.md
MFP_AHB_7SD_SCANNER -- requirements
Module: mfp_ahb_7sd_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 Parameter PRESCALE SHALL default to 50000 and set the clocks each digit is driven; legal values are 1 or more.
REQ-003 Parameter BLANK_CYCLES SHALL default to 64 and set the anti-ghost gap, in clocks, before each digit; legal values are 1 or more.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  one-cycle write strobe into the shadow registers.
REQ-007 wr_sel  input  2  write target: 0 = codes of digits 3..0 (wr_data[19:0], 5 bits per digit, digit 0 in the LSBs); 1 = codes of digits 7..4; 2 = dp mask (wr_data[7:0]); 3 = enable mask (wr_data[7:0]).
REQ-008 wr_data  input  32  write data; unused bits are ignored.
REQ-009 anode  output  8  digit selects, active-low, registered.
REQ-010 digit_data  output  6  to the decoder: bit 5 = decimal point (active-low), bits 4:0 = code 0-31; registered.
REQ-011 frame_sync  output  1  one-cycle pulse at each frame commit.

Function
REQ-012 Shadow registers: wr_en SHALL update the wr_sel target on the same clock edge; the displayed output is unaffected until the next commit.
REQ-013 Active registers SHALL load from the shadow registers only at a commit; a write in the commit cycle SHALL miss that commit and appear at the following one.
REQ-014 FSM states: BLANK and SHOW; one counter cnt; digit index idx in the range 0..7.
REQ-015 BLANK: anode = 8'hFF; digit_data = {~dp[idx], code[idx]} from the active registers; lasts BLANK_CYCLES clocks, then the FSM moves to SHOW with cnt = 0.
REQ-016 SHOW: anode[idx] = 0 when enable[idx] = 1, otherwise anode = 8'hFF; digit_data as in BLANK; lasts PRESCALE clocks.
REQ-017 End of SHOW: the FSM moves to BLANK and idx increments, wrapping from 7 to 0.
REQ-018 Commit: on the wrap from 7 to 0, the same edge SHALL copy shadow to active, and frame_sync SHALL be 1 for exactly that first BLANK cycle of digit 0.
REQ-019 Timing: period per digit = PRESCALE + BLANK_CYCLES clocks; frame period = 8 x that.
REQ-020 Two digits SHALL never have their anode low in the same cycle, and anode SHALL never change directly from one low digit to another.
REQ-021 Code 31 SHALL be the blank code; the block passes it through and does not force anode high for it.
REQ-022 Counter widths SHALL be $clog2(max(PRESCALE, BLANK_CYCLES)) + 1.

Reset
REQ-023 Reset SHALL force: state BLANK, idx 0, cnt 0, anode 8'hFF, digit_data 6'h3F, frame_sync 0.
REQ-024 Reset SHALL set both shadow and active registers to: all codes 5'd31, dp mask 8'h00, enable mask 8'hFF.
REQ-025 Reset asserted mid-frame SHALL take effect on the next edge; any write in the same cycle is discarded.
REQ-026 After reset deasserts, the first SHOW of digit 0 SHALL start BLANK_CYCLES clocks later.
REQ-027 No commit or frame_sync pulse SHALL occur at reset exit.

Structure
REQ-028 Package mfp_7sd_pkg SHALL hold: the state enum, the wr_sel constants (SEL_LO, SEL_HI, SEL_DP, SEL_EN), the blank code 5'd31, and the digit count 8.
REQ-029 Sub-module mfp_7sd_regbank SHALL contain the shadow/active register pairs and the commit logic; the FSM and counters stay in the top module.

Verification (PRESCALE=4, BLANK_CYCLES=2)
REQ-030 Reset, then idle: cycles 0-1 anode=FF; cycles 2-5 anode=FE with digit_data=3F; cycles 6-7 anode=FF; cycles 8-11 anode=FD; frame period 48 cycles.
REQ-031 Write SEL_LO 20'h18820 (codes 0,1,2,3) mid-frame: outputs unchanged until the next frame_sync; then digit 0 shows digit_data=20, digit 1 shows 21, digit 2 shows 22, digit 3 shows 23.
REQ-032 Write SEL_DP 8'h01 and SEL_EN 8'hF0, then wait for a commit: digit 0 shows digit_data[5]=0 with anode=FF during its SHOW; digit 4 shows anode=EF.
REQ-033 Write in the exact frame_sync cycle: the new value is absent this frame and present after the next frame_sync (48 cycles later).
REQ-034 Assert reset during the SHOW of digit 5: the next cycle shows anode=FF and digit_data=3F, and the REQ-030 sequence restarts.
REQ-035 Assertion bench-wide: popcount(~anode) is 1 or less, and no two consecutive cycles have different zero bits in anode.
